// File: rtl/mfp_botbuf_pkg.sv
// Shared constants and FSM encoding for the Rojobot update buffer.
// Optional overflow counter is enabled with `MFP_BOTBUF_OVF_CNT_EN`.
package mfp_botbuf_pkg;

    localparam int BOTBUF_DEPTH  = 4;
    localparam int BOTBUF_INFO_W = 32;
    localparam int BOTBUF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESENT = 2'b01,
        ST_ACKED   = 2'b10
    } botbuf_state_e;

endpackage

// File: rtl/mfp_botbuf_fifo.sv
// Synchronous snapshot FIFO with extra-MSB pointers; the head word is read
// combinationally from the storage array.
module mfp_botbuf_fifo
    import mfp_botbuf_pkg::*;
#(
    parameter int DEPTH = BOTBUF_DEPTH,
    parameter int WIDTH = BOTBUF_INFO_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      wptr_d;
    logic [AW:0]      rptr_q;
    logic [AW:0]      rptr_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // A push at full is still legal when the head leaves on the same edge.
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;

    // Next-pointer computation.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mfp_botinfo_buffer.sv
// Rojobot update buffer: synchronizes bot_upd, queues bot_info snapshots and
// hands them to the CPU with an update/ack handshake. Macro: MFP_BOTBUF_OVF_CNT_EN.
module mfp_botinfo_buffer
    import mfp_botbuf_pkg::*;
#(
    parameter int DEPTH  = BOTBUF_DEPTH,
    parameter int INFO_W = BOTBUF_INFO_W,
    parameter int CNT_W  = BOTBUF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bot_upd,
    input  logic [INFO_W-1:0]      bot_info,
    input  logic                   IO_INT_ACK,
    output logic                   IO_BotUpdt_Sync,
    output logic [INFO_W-1:0]      IO_BotInfo,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       ovf_count
);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              s3_q, s3_d;
    botbuf_state_e     state_q, state_d;
    logic              sync_q, sync_d;
    logic [INFO_W-1:0] info_q, info_d;

    logic              push_stb_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [INFO_W-1:0] fifo_rdata_s;

    assign push_stb_s = s2_q & ~s3_q;
    assign pop_s      = (state_q == ST_PRESENT) & IO_INT_ACK;
    assign push_s     = push_stb_s & (~fifo_full_s | pop_s);

    mfp_botbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INFO_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bot_info),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Synchronizer chain plus edge-detect delay stage.
    always_comb begin
        s1_d = bot_upd;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Handshake FSM. Releasing the ack always passes through IDLE, which
    // re-presents on the following edge, so Sync stays low between entries.
    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        info_d  = info_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_PRESENT;
                    sync_d  = 1'b1;
                    info_d  = fifo_rdata_s;
                end else begin
                    sync_d  = 1'b0;
                end
            end
            ST_PRESENT: begin
                if (IO_INT_ACK) begin
                    state_d = ST_ACKED;
                    sync_d  = 1'b0;
                end else begin
                    sync_d  = 1'b1;
                end
            end
            ST_ACKED: begin
                sync_d = 1'b0;
                if (!IO_INT_ACK) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sync_d  = 1'b0;
            end
        endcase
    end

    // Synchronizer, FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= ST_IDLE;
            sync_q  <= 1'b0;
            info_q  <= {INFO_W{1'b0}};
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            state_q <= state_d;
            sync_q  <= sync_d;
            info_q  <= info_d;
        end
    end

    assign IO_BotUpdt_Sync = sync_q;
    assign IO_BotInfo      = info_q;

`ifdef MFP_BOTBUF_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic             drop_s;

    assign drop_s = push_stb_s & fifo_full_s & ~pop_s;

    // Saturating count of dropped updates.
    always_comb begin
        ovf_d = ovf_q;
        if (drop_s && (ovf_q != {CNT_W{1'b1}})) begin
            ovf_d = ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= {CNT_W{1'b0}};
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mfp_botinfo_buffer.sv
// Directed bench for mfp_botinfo_buffer: a vector table for a single update
// plus hand-written burst, overflow, held-ack and reset sequences.
module tb_mfp_botinfo_buffer;

`ifdef MFP_BOTBUF_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        bot_upd;
    logic [31:0] bot_info;
    logic        IO_INT_ACK;
    logic        IO_BotUpdt_Sync;
    logic [31:0] IO_BotInfo;
    logic [2:0]  fifo_level;
    logic [7:0]  ovf_count;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  exp_ovf = 8'd0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mfp_botinfo_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .bot_upd         (bot_upd),
        .bot_info        (bot_info),
        .IO_INT_ACK      (IO_INT_ACK),
        .IO_BotUpdt_Sync (IO_BotUpdt_Sync),
        .IO_BotInfo      (IO_BotInfo),
        .fifo_level      (fifo_level),
        .ovf_count       (ovf_count)
    );

    typedef struct {
        logic        rst;
        logic        upd;
        logic [31:0] info;
        logic        ack;
        logic        e_sync;
        logic [31:0] e_info;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t tbl[10];

    task automatic step(input logic rst, input logic upd, input logic [31:0] info, input logic ack);
        reset      = rst;
        bot_upd    = upd;
        bot_info   = info;
        IO_INT_ACK = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic e_sync, input logic [31:0] e_info,
                              input logic [2:0] e_lvl, input logic [7:0] e_ovf);
        cmp({tag, ".sync"},  {31'd0, IO_BotUpdt_Sync}, {31'd0, e_sync});
        cmp({tag, ".info"},  IO_BotInfo, e_info);
        cmp({tag, ".level"}, {29'd0, fifo_level}, {29'd0, e_lvl});
        cmp({tag, ".ovf"},   {24'd0, ovf_count}, {24'd0, e_ovf});
    endtask

    // Three high cycles then two low: push lands on the third edge.
    task automatic send_update(input logic [31:0] info);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, info, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, info, 1'b0);
    endtask

    // Acknowledge every queued value, starting from a presented head.
    task automatic drain(input string tag);
        logic [31:0] v;
        logic [2:0]  lvl;
        v = 32'd0;
        while (exp_q.size() > 0) begin
            lvl = 3'(exp_q.size());
            v   = exp_q.pop_front();
            expect_out({tag, ".present"}, 1'b1, v, lvl, exp_ovf);
            step(1'b0, 1'b0, 32'd0, 1'b1);
            expect_out({tag, ".acked"}, 1'b0, v, lvl - 3'd1, exp_ovf);
            step(1'b0, 1'b0, 32'd0, 1'b0);
            expect_out({tag, ".gap"}, 1'b0, v, lvl - 3'd1, exp_ovf);
            step(1'b0, 1'b0, 32'd0, 1'b0);
        end
        expect_out({tag, ".done"}, 1'b0, v, 3'd0, exp_ovf);
    endtask

    initial begin
        // Reset, then one update of 32'h1234_5678 acknowledged once.
        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0};
        tbl[2] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         3'd0};
        tbl[3] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         3'd0};
        tbl[4] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         3'd1};
        tbl[5] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 3'd1};
        tbl[6] = '{1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 3'd0};
        tbl[7] = '{1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 3'd0};
        tbl[8] = '{1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 3'd0};
        tbl[9] = '{1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 3'd0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].upd, tbl[i].info, tbl[i].ack);
            expect_out($sformatf("single[%0d]", i), tbl[i].e_sync, tbl[i].e_info, tbl[i].e_lvl, 8'd0);
        end

        // Burst of three, presented in order.
        send_update(32'hAAAA_0001);
        send_update(32'hBBBB_0002);
        send_update(32'hCCCC_0003);
        expect_out("burst.queued", 1'b1, 32'hAAAA_0001, 3'd3, exp_ovf);
        exp_q = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        drain("burst");

        // Six updates into four entries: two drops.
        for (int i = 0; i < 6; i++) send_update(32'hD000_0000 + 32'(i));
        exp_ovf = OVF_EN ? 8'd2 : 8'd0;
        expect_out("ovf.full", 1'b1, 32'hD000_0000, 3'd4, exp_ovf);

        // Push and pop on the same edge while full.
        step(1'b0, 1'b1, 32'hD000_0006, 1'b0);
        step(1'b0, 1'b1, 32'hD000_0006, 1'b0);
        step(1'b0, 1'b1, 32'hD000_0006, 1'b1);
        expect_out("simul.edge", 1'b0, 32'hD000_0000, 3'd4, exp_ovf);
        step(1'b0, 1'b0, 32'hD000_0006, 1'b0);
        expect_out("simul.gap", 1'b0, 32'hD000_0000, 3'd4, exp_ovf);
        step(1'b0, 1'b0, 32'hD000_0006, 1'b0);
        exp_q = '{32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0006};
        drain("ovf");

        // Ack held high for ten cycles pops exactly once.
        send_update(32'hE000_0000);
        send_update(32'hE000_0001);
        expect_out("hold.queued", 1'b1, 32'hE000_0000, 3'd2, exp_ovf);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            expect_out($sformatf("hold[%0d]", i), 1'b0, 32'hE000_0000, 3'd1, exp_ovf);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        expect_out("hold.release", 1'b0, 32'hE000_0000, 3'd1, exp_ovf);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        exp_q = '{32'hE000_0001};
        drain("hold");

        // Reset with three queued entries flushes everything.
        send_update(32'hF000_0000);
        send_update(32'hF000_0001);
        send_update(32'hF000_0002);
        expect_out("rst.queued", 1'b1, 32'hF000_0000, 3'd3, exp_ovf);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        exp_ovf = 8'd0;
        expect_out("rst.flush", 1'b0, 32'd0, 3'd0, exp_ovf);
        step(1'b1, 1'b1, 32'h6060_6060, 1'b0);
        expect_out("rst.hold", 1'b0, 32'd0, 3'd0, exp_ovf);

        // bot_upd high across reset release pushes exactly once.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 32'h6060_6060, 1'b0);
            if (i < 3)
                expect_out($sformatf("rel[%0d]", i), 1'b0, 32'd0, 3'd0, exp_ovf);
            else if (i == 3)
                expect_out($sformatf("rel[%0d]", i), 1'b0, 32'd0, 3'd1, exp_ovf);
            else
                expect_out($sformatf("rel[%0d]", i), 1'b1, 32'h6060_6060, 3'd1, exp_ovf);
        end
        exp_q = '{32'h6060_6060};
        drain("rel");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
